// File: rtl/cnn_pkg.sv
// cnn_pkg
//   Shared constants, types and helpers for the conv datapath stages.
//   - DATA_W / FRAC_BITS : activation, weight and bias format (signed Q8.8 with sign)
//   - PROD_W             : stage-2 product width (two DATA_W values multiplied)
//   - ACC_W              : accumulator width, wide enough for 27 full-scale products
//   - OUT_DIM / POS_W    : output map side length and its coordinate width
//   - sat_relu()         : accumulator -> DATA_W pixel (ReLU, rescale, saturate)
package cnn_pkg;

  localparam int DATA_W    = 17;
  localparam int PROD_W    = 2 * DATA_W;
  localparam int FRAC_BITS = 8;
  localparam int ACC_W     = PROD_W + 5;
  localparam int N_PROD    = 27;
  localparam int OUT_DIM   = 6;
  localparam int POS_W     = $clog2(OUT_DIM);

  typedef logic signed [DATA_W-1:0] data_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  // Largest positive DATA_W value, held at accumulator width for the compare.
  localparam acc_t SAT_MAX = acc_t'((1 << (DATA_W - 1)) - 1);

  // The accumulator carries 2*FRAC_BITS fractional bits; dropping FRAC_BITS
  // of them returns to the DATA_W Q format. Negative sums clamp to zero
  // before the shift, so the shift only ever sees non-negative values and
  // truncation rounds toward zero.
  function automatic data_t sat_relu(input acc_t acc);
    acc_t  shifted;
    data_t result;
    shifted = acc >>> FRAC_BITS;
    if (acc[ACC_W-1]) begin
      result = '0;
    end else if (shifted > SAT_MAX) begin
      result = data_t'(SAT_MAX);
    end else begin
      result = data_t'(shifted);
    end
    return result;
  endfunction

endpackage

// File: rtl/s3_accum_bias_relu_add3_reg.sv
// add3_reg
//   Registered signed three-input adder used as one node of the stage-3
//   adder tree. The sum and its valid bit load together when en is high, so
//   the whole tree stalls as a unit.
//   Ports:
//   - clk, rst_n  : clock, asynchronous active-low reset
//   - clear       : synchronous flush of the valid bit (data is left alone)
//   - en          : pipeline advance; register loads only when high
//   - in_valid    : valid bit travelling with a, b, c
//   - a, b, c     : signed operands, already extended to W bits
//   - out_valid   : registered valid
//   - sum         : registered a + b + c
module add3_reg #(
  parameter int W = 39
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                en,
  input  logic                in_valid,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic signed [W-1:0] c,
  output logic                out_valid,
  output logic signed [W-1:0] sum
);

  logic signed [W-1:0] sum_d, sum_q;
  logic                valid_d, valid_q;

  // Operands are pre-extended by the caller to a width that cannot overflow,
  // so a plain add is exact. clear wins over a simultaneous load.
  always_comb begin
    sum_d   = sum_q;
    valid_d = valid_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (en) begin
      sum_d   = a + b + c;
      valid_d = in_valid;
    end
  end

  // Node register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      valid_q <= valid_d;
    end
  end

  assign sum       = sum_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/s3_accum_bias_relu.sv
// s3_accum_bias_relu
//   Stage 3 of the conv datapath. Reduces the 27 products of one 3x3x3 window
//   through a registered 3-level adder tree, adds the filter bias, applies
//   ReLU and rescales/saturates back to DATA_W. Each result leaves tagged
//   with its output-map (row, col) and an end-of-map flag.
//   Four register stages (S1 9x add3, S2 3x add3, S3 final sum + bias,
//   S4 output) give a 4-cycle latency; the whole pipe stalls together when
//   the output is held by backpressure.
//   Ports:
//   - clk, rst_n           : clock, asynchronous active-low reset
//   - clear                : sync flush of all valids and position counters
//   - in_valid / in_ready  : product-side handshake (in_ready is combinational)
//   - mult_res[27]         : signed products, index k*9 + 3*i + j
//   - bias                 : signed filter bias, sampled with each window
//   - out_valid/out_ready  : pixel-side handshake
//   - out_data             : ReLU'd, saturated pixel in the input Q format
//   - out_row, out_col     : coordinates of the presented pixel
//   - out_last             : presented pixel is the last of the map
module s3_accum_bias_relu
  import cnn_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  prod_t            mult_res [N_PROD],
  input  data_t            bias,
  output logic             out_valid,
  input  logic             out_ready,
  output data_t            out_data,
  output logic [POS_W-1:0] out_row,
  output logic [POS_W-1:0] out_col,
  output logic             out_last
);

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(OUT_DIM - 1);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

  logic adv;

  acc_t       s1_sum [9];
  logic [8:0] s1_valid_vec;
  logic       s1_valid;
  acc_t       s2_sum [3];
  logic [2:0] s2_valid_vec;
  logic       s2_valid;

  data_t            bias1_d, bias1_q;
  data_t            bias2_d, bias2_q;
  acc_t             bias_ext;
  acc_t             s3_sum_d, s3_sum_q;
  logic             s3_valid_d, s3_valid_q;
  data_t            out_data_d, out_data_q;
  logic             out_valid_d, out_valid_q;
  logic [POS_W-1:0] row_d, row_q;
  logic [POS_W-1:0] col_d, col_q;
  logic             out_xfer;

  // The output register frees up whenever it is empty or being taken this
  // cycle; every stage moves in lockstep on that single enable.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;
  assign out_xfer = out_valid_q && out_ready;

  // S1: nine partial sums, one per (channel, row) triple of products.
  for (genvar m = 0; m < 9; m++) begin : g_s1
    add3_reg #(.W(ACC_W)) u_add3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .en        (adv),
      .in_valid  (in_valid),
      .a         (acc_t'(mult_res[3*m])),
      .b         (acc_t'(mult_res[3*m+1])),
      .c         (acc_t'(mult_res[3*m+2])),
      .out_valid (s1_valid_vec[m]),
      .sum       (s1_sum[m])
    );
  end

  // All lanes see the same valid and enable, so they always agree; the AND
  // just merges them into the stage valid.
  assign s1_valid = &s1_valid_vec;

  // S2: three per-channel sums.
  for (genvar g = 0; g < 3; g++) begin : g_s2
    add3_reg #(.W(ACC_W)) u_add3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .en        (adv),
      .in_valid  (s1_valid),
      .a         (s1_sum[3*g]),
      .b         (s1_sum[3*g+1]),
      .c         (s1_sum[3*g+2]),
      .out_valid (s2_valid_vec[g]),
      .sum       (s2_sum[g])
    );
  end

  assign s2_valid = &s2_valid_vec;

  // Bias is in DATA_W format (FRAC_BITS fractional bits) while products carry
  // twice that, so it is aligned by shifting up FRAC_BITS after extension.
  assign bias_ext = acc_t'(bias2_q) <<< FRAC_BITS;

  // Next-state for bias delay line, S3, S4 and the position counters.
  // The bias rides two registers so it meets the S2 sums of its own window,
  // which keeps a mid-stream bias change from touching earlier windows.
  // clear drops every valid and zeroes the counters but leaves out_data.
  always_comb begin
    bias1_d     = bias1_q;
    bias2_d     = bias2_q;
    s3_sum_d    = s3_sum_q;
    s3_valid_d  = s3_valid_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    row_d       = row_q;
    col_d       = col_q;

    if (clear) begin
      s3_valid_d  = 1'b0;
      out_valid_d = 1'b0;
      row_d       = '0;
      col_d       = '0;
    end else begin
      if (adv) begin
        bias1_d     = bias;
        bias2_d     = bias1_q;
        s3_sum_d    = s2_sum[0] + s2_sum[1] + s2_sum[2] + bias_ext;
        s3_valid_d  = s2_valid;
        out_data_d  = sat_relu(s3_sum_q);
        out_valid_d = s3_valid_q;
      end
      // Raster scan of the output map, wrapping back to the origin after
      // the last pixel.
      if (out_xfer) begin
        if (col_q == POS_LAST) begin
          col_d = '0;
          row_d = (row_q == POS_LAST) ? '0 : row_q + POS_ONE;
        end else begin
          col_d = col_q + POS_ONE;
        end
      end
    end
  end

  // Stage registers for bias, S3, S4 and the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bias1_q     <= '0;
      bias2_q     <= '0;
      s3_sum_q    <= '0;
      s3_valid_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
    end else begin
      bias1_q     <= bias1_d;
      bias2_q     <= bias2_d;
      s3_sum_q    <= s3_sum_d;
      s3_valid_q  <= s3_valid_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      row_q       <= row_d;
      col_q       <= col_d;
    end
  end

  // The counters point at the pixel currently presented, since they only
  // step when that pixel is taken.
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign out_last  = (row_q == POS_LAST) && (col_q == POS_LAST);

endmodule

// File: tb/tb_s3_accum_bias_relu.sv
// tb_s3_accum_bias_relu
//   Directed plus randomized bench for the stage-3 accumulate/bias/ReLU block.
//   Expected pixels come from plain integer arithmetic over the window, and
//   expected coordinates from a running count of delivered pixels.
module tb_s3_accum_bias_relu;
  import cnn_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  prod_t            mult_res [N_PROD];
  data_t            bias;
  logic             out_valid;
  logic             out_ready = 1'b1;
  data_t            out_data;
  logic [POS_W-1:0] out_row;
  logic [POS_W-1:0] out_col;
  logic             out_last;

  int total = 0;
  int bad = 0;

  int expQ[$];
  int outIdx = 0;
  int outSeen = 0;
  int lastSeen = 0;
  int cycleNo = 0;
  int firstOutCycle = -1;
  int lastOutCycle = 0;

  logic lastOutValid;
  int   lastOutData;
  int   lastRow;
  int   lastCol;
  logic lastLast;
  logic lastInReady;
  logic lastXfer;
  logic prevStalled = 1'b0;
  int   prevData = 0;

  always #5 clk = ~clk;

  s3_accum_bias_relu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mult_res  (mult_res),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last)
  );

  // One comparison: counted always, reported only on mismatch.
  task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                             input logic signed [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Reference pixel: exact window sum in Q(2*FRAC) plus the bias scaled up,
  // then ReLU, drop FRAC_BITS fractional bits, clamp to the DATA_W maximum.
  function automatic int refPixel();
    longint s;
    s = 0;
    for (int k = 0; k < N_PROD; k++) s += longint'(mult_res[k]);
    s += longint'(bias) * 256;
    if (s < 0) return 0;
    s = s / 256;
    if (s > 65535) return 65535;
    return int'(s);
  endfunction

  function automatic prod_t randProd();
    if ($urandom_range(0, 3) == 0)
      return prod_t'({$urandom, $urandom});
    return prod_t'(longint'($urandom_range(0, 1 << 22)) - longint'(1 << 21));
  endfunction

  task automatic applyStimulus(input logic v, input bit useRand, input longint pConst,
                               input int bConst);
    in_valid = v;
    for (int k = 0; k < N_PROD; k++)
      mult_res[k] = useRand ? randProd() : prod_t'(pConst);
    bias = useRand ? data_t'(int'($urandom_range(0, 131071)) - 65536) : data_t'(bConst);
  endtask

  // One clock: sample and score at the falling edge, then step past the
  // rising edge so new inputs are driven well clear of it.
  task automatic tick();
    int e;
    @(negedge clk);
    cycleNo++;
    lastOutValid = out_valid;
    lastOutData  = int'(out_data);
    lastRow      = int'(out_row);
    lastCol      = int'(out_col);
    lastLast     = out_last;
    lastInReady  = in_ready;
    lastXfer     = in_valid && in_ready && rst_n && !clear;
    if (!rst_n || clear) begin
      expQ.delete();
      outIdx = 0;
      prevStalled = 1'b0;
    end else begin
      if (prevStalled) begin
        checkOutput("stall valid held", out_valid, 1);
        checkOutput("stall data held", out_data, prevData);
      end
      if (out_valid && out_ready) begin
        outSeen++;
        lastOutCycle = cycleNo;
        if (firstOutCycle < 0) firstOutCycle = cycleNo;
        if (out_last) lastSeen++;
        if (expQ.size() == 0) begin
          checkOutput("spurious output", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("pixel data", out_data, e);
          checkOutput("pixel row", out_row, (outIdx / OUT_DIM) % OUT_DIM);
          checkOutput("pixel col", out_col, outIdx % OUT_DIM);
          checkOutput("pixel last", out_last, (outIdx % (OUT_DIM * OUT_DIM)) == OUT_DIM * OUT_DIM - 1);
        end
        outIdx++;
      end
      prevStalled = out_valid && !out_ready;
      prevData = int'(out_data);
      if (in_valid && in_ready) expQ.push_back(refPixel());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic waitOutputs(input int target, input int budget);
    int n;
    n = 0;
    while (outSeen < target && n < budget) begin
      tick();
      n++;
    end
    checkOutput("output wait timeout", outSeen >= target, 1);
  endtask

  initial begin
    int base;
    int sent;
    int iter;

    applyStimulus(0, 0, 0, 0);
    tick();
    tick();
    checkOutput("reset out_valid", lastOutValid, 0);
    checkOutput("reset out_data", lastOutData, 0);
    checkOutput("reset out_row", lastRow, 0);
    checkOutput("reset out_col", lastCol, 0);
    checkOutput("reset out_last", lastLast, 0);
    checkOutput("reset in_ready", lastInReady, 1);
    rst_n = 1'b1;
    tick();

    // All-ones window: 27 * 1.0 = 27.0 after exactly four cycles at (0,0).
    applyStimulus(1, 0, 65536, 0);
    tick();
    checkOutput("ones accepted", lastXfer, 1);
    applyStimulus(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("ones latency early", lastOutValid, 0);
    end
    tick();
    checkOutput("ones latency 4", lastOutValid, 1);
    checkOutput("ones data", lastOutData, 6912);
    checkOutput("ones row", lastRow, 0);
    checkOutput("ones col", lastCol, 0);

    // Negative sum clamps to zero.
    base = outSeen;
    applyStimulus(1, 0, -65536, 256);
    tick();
    applyStimulus(0, 0, 0, 0);
    waitOutputs(base + 1, 10);
    checkOutput("relu data", lastOutData, 0);

    // Full-scale products saturate.
    base = outSeen;
    applyStimulus(1, 0, longint'(32'hFFFF_FFFF), 65535);
    tick();
    applyStimulus(0, 0, 0, 0);
    waitOutputs(base + 1, 10);
    checkOutput("saturate data", lastOutData, 65535);

    // Back to the origin, then a full map plus one back-to-back.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    base = outSeen;
    lastSeen = 0;
    firstOutCycle = -1;
    for (int i = 0; i < 37; i++) begin
      applyStimulus(1, 1, 0, 0);
      tick();
    end
    applyStimulus(0, 0, 0, 0);
    waitOutputs(base + 37, 20);
    checkOutput("back-to-back span", lastOutCycle - firstOutCycle, 36);
    checkOutput("last flag count", lastSeen, 1);
    checkOutput("wrap row", lastRow, 0);
    checkOutput("wrap col", lastCol, 0);

    // Random gaps and backpressure.
    base = outSeen;
    sent = 0;
    iter = 0;
    while (sent < 10 && iter < 300) begin
      applyStimulus($urandom_range(0, 2) != 0, 1, 0, 0);
      out_ready = $urandom_range(0, 1) == 1;
      tick();
      if (lastXfer) sent++;
      iter++;
    end
    checkOutput("random windows sent", sent, 10);
    applyStimulus(0, 0, 0, 0);
    out_ready = 1'b1;
    waitOutputs(base + 10, 40);
    checkOutput("random queue drained", expQ.size(), 0);

    // clear with three windows in flight.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 0, 0);
      tick();
    end
    applyStimulus(0, 0, 0, 0);
    base = outSeen;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    checkOutput("clear no output", outSeen - base, 0);
    applyStimulus(1, 1, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    tick();
    checkOutput("clear next valid", lastOutValid, 1);
    checkOutput("clear next row", lastRow, 0);
    checkOutput("clear next col", lastCol, 0);

    // Asynchronous reset with three windows in flight.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 0, 0);
      tick();
    end
    applyStimulus(0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    base = outSeen;
    tick();
    checkOutput("reset mid out_valid", lastOutValid, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    checkOutput("reset no output", outSeen - base, 0);
    applyStimulus(1, 1, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    tick();
    checkOutput("reset next valid", lastOutValid, 1);
    checkOutput("reset next row", lastRow, 0);
    checkOutput("reset next col", lastCol, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
